// File: rtl/avalon_burst_responder_pkg.sv
// ---------------------------------------------------------------------------
// avalon_burst_responder_pkg
// Shared definitions for the Avalon-MM burst responder: FSM state encoding,
// burstcount width, and the helper that maps a burstcount of 0 to 1.
// ---------------------------------------------------------------------------
package avalon_burst_responder_pkg;

    localparam int BURST_W = 3;
    localparam logic [BURST_W-1:0] BC_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

    // A burstcount of zero is treated as a single beat.
    function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] bc);
        return (bc == {BURST_W{1'b0}}) ? BC_ONE : bc;
    endfunction

endpackage

// File: rtl/avalon_burst_responder_ram.sv
// ---------------------------------------------------------------------------
// avalon_responder_ram
// Single-port, byte-enabled RAM of 2^ADDR_WIDTH 32-bit words with one cycle
// of synchronous read latency. Contents are never reset.
// Ports:
//   clk      - clock
//   addr_i   - word address (read and write share it)
//   be_i     - per-byte write enables; all-zero means no write
//   wdata_i  - write data
//   rdata_o  - registered read data of the word addressed last cycle
// ---------------------------------------------------------------------------
module avalon_responder_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem_q [DEPTH];

    // Byte-lane writes and registered read of the addressed word.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/avalon_burst_responder.sv
// ---------------------------------------------------------------------------
// avalon_burst_responder
// Avalon-MM slave answering write and read bursts from a local RAM.
// Writes are accepted beat-by-beat without stalls; reads stall the master
// (waitrequest=1) while the burst is streamed back, beat k of a read
// accepted in cycle T appearing in cycle T+2+k.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   avs_address        - word address of the burst start
//   avs_writedata      - write beat data
//   avs_byteenable     - write byte lanes
//   avs_burstcount     - beats per burst (0 treated as 1)
//   avs_write/avs_read - command strobes
//   avs_waitrequest    - stall
//   avs_readdatavalid  - read beat valid
//   avs_readdata       - read beat data
// ---------------------------------------------------------------------------
module avalon_burst_responder
    import avalon_burst_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:2]        avs_address,
    input  logic [31:0]        avs_writedata,
    input  logic [3:0]         avs_byteenable,
    input  logic [BURST_W-1:0] avs_burstcount,
    input  logic               avs_write,
    input  logic               avs_read,
    output logic               avs_waitrequest,
    output logic               avs_readdatavalid,
    output logic [31:0]        avs_readdata
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [BURST_W-1:0]    remain_q,  remain_d;
    logic                  waitreq_q, waitreq_d;
    logic                  rvalid_q,  rvalid_d;

    logic [ADDR_WIDTH-1:0] cmd_word_s;
    logic [BURST_W-1:0]    cmd_bc_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [3:0]            ram_be_s;
    logic [31:0]           ram_rdata_s;
    logic                  unused_s;

    assign cmd_word_s = avs_address[ADDR_WIDTH+1:2];
    assign cmd_bc_s   = eff_burst(avs_burstcount);
    assign unused_s   = ^avs_address[31:ADDR_WIDTH+2];

    // Next-state, burst counters and RAM port steering.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        rvalid_d   = 1'b0;
        ram_addr_s = addr_q;
        ram_be_s   = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                ram_addr_s = cmd_word_s;
                // waitreq_q is only high here in the first cycle after reset;
                // no command is taken while the master sees a stall.
                if (!waitreq_q && avs_write) begin
                    ram_be_s = avs_byteenable;
                    addr_d   = cmd_word_s + ADDR_ONE;
                    remain_d = cmd_bc_s - BC_ONE;
                    if (cmd_bc_s > BC_ONE) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!waitreq_q && avs_read) begin
                    addr_d   = cmd_word_s;
                    remain_d = cmd_bc_s;
                    state_d  = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (avs_write) begin
                    ram_be_s = avs_byteenable;
                    addr_d   = addr_q + ADDR_ONE;
                    remain_d = remain_q - BC_ONE;
                    if (remain_q == BC_ONE) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                // Issue one RAM read per cycle; once all are issued the last
                // beat is on the bus and the FSM leaves in the next cycle.
                if (remain_q != {BURST_W{1'b0}}) begin
                    rvalid_d = 1'b1;
                    addr_d   = addr_q + ADDR_ONE;
                    remain_d = remain_q - BC_ONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        waitreq_d = (state_d == ST_READ);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= {ADDR_WIDTH{1'b0}};
            remain_q  <= {BURST_W{1'b0}};
            waitreq_q <= 1'b1;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            waitreq_q <= waitreq_d;
            rvalid_q  <= rvalid_d;
        end
    end

    avalon_responder_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .addr_i  (ram_addr_s),
        .be_i    (ram_be_s),
        .wdata_i (avs_writedata),
        .rdata_o (ram_rdata_s)
    );

    assign avs_waitrequest   = waitreq_q;
    assign avs_readdatavalid = rvalid_q;
    assign avs_readdata      = ram_rdata_s;

endmodule

// File: doc/avalon_burst_responder.md
AVALON_BURST_RESPONDER -- requirements
Module: avalon_burst_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, giving the backing RAM depth of 2^ADDR_WIDTH 32-bit words.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port avs_address, input, [31:2]: word address of the burst start.
REQ-005 The block SHALL have port avs_writedata, input, 32 bits: write beat data.
REQ-006 The block SHALL have port avs_byteenable, input, 4 bits: per-beat byte lanes for writes, ignored on reads.
REQ-007 The block SHALL have port avs_burstcount, input, 3 bits: beats in the burst, 1..7, with 0 treated as 1.
REQ-008 The block SHALL have ports avs_write and avs_read, input, 1 bit each: command strobes.
REQ-009 The block SHALL have port avs_waitrequest, output, 1 bit: stall.
REQ-010 The block SHALL have port avs_readdatavalid, output, 1 bit: read beat valid.
REQ-011 The block SHALL have port avs_readdata, output, 32 bits: read beat data.

Function
REQ-012 The block SHALL implement the states IDLE, WRITE and READ.
REQ-013 RAM word index SHALL be address[ADDR_WIDTH+1:2]; upper bits ignored; beat address increments by 1, wrapping modulo 2^ADDR_WIDTH.
REQ-014 In IDLE, avs_waitrequest SHALL be 0.
REQ-015 IDLE with avs_write=1 SHALL accept beat 0 the same cycle: RAM written with writedata/byteenable; if burstcount>1 the block goes to WRITE with remaining=burstcount-1 and next_addr=addr+1, else it stays in IDLE.
REQ-016 In WRITE, avs_waitrequest SHALL be 0; each cycle with avs_write=1 writes one beat at next_addr, increments next_addr and decrements remaining; when remaining reaches 0 the block goes to IDLE; avs_read is ignored in WRITE; cycles with avs_write=0 are idle beats.
REQ-017 IDLE with avs_read=1 and avs_write=0 SHALL accept the command at cycle T, latch the address and burstcount, and go to READ.
REQ-018 IDLE with avs_write=1 and avs_read=1 SHALL accept the write only; the read stays pending.
REQ-019 In READ, avs_waitrequest SHALL be 1; one RAM read is issued per cycle from T+1; beat k SHALL appear with avs_readdatavalid=1 at cycle T+2+k, with consecutive beats and no gaps.
REQ-020 READ SHALL return to IDLE in the cycle after the last readdatavalid beat; a new command is accepted from then on.
REQ-021 avs_readdata SHALL equal the RAM output when avs_readdatavalid=1, and is don't-care otherwise.
REQ-022 The RAM SHALL have 1-cycle synchronous read latency, with per-byte write enables.
REQ-023 Read data SHALL reflect every write beat accepted before the read command.

Reset
REQ-024 While rst=1: state=IDLE, avs_waitrequest=1, avs_readdatavalid=0, counters=0.
REQ-025 avs_waitrequest SHALL fall in the first cycle after rst deasserts.
REQ-026 Reset mid-burst SHALL abandon the burst with no further readdatavalid; RAM contents are not cleared, and already-written beats persist.

Structure
REQ-027 State encodings and the burstcount width constant SHALL live in the shared defines package.
REQ-028 The RAM SHALL be one sub-module, avalon_responder_ram: single-port, byte-enabled, ADDR_WIDTH-parameterised.

Verification
REQ-029 Single write then read: write 0x1000 data 0xDEADBEEF be=1111 bc=1; read 0x1000 bc=1 -> readdatavalid 2 cycles after acceptance, readdata 0xDEADBEEF.
REQ-030 4-beat line: write bc=4 at 0x2000 with data 0x11111111..0x44444444; read bc=4 -> 4 consecutive valid beats in order; waitrequest=1 for 5 cycles after read acceptance.
REQ-031 Byte lanes: write 0xFFFFFFFF be=1111, then 0x00000000 be=0101 at the same address; read -> 0xFF00FF00.
REQ-032 Wrap and 3-beat burst: ADDR_WIDTH=12, bc=3 write at word 4095 -> words 4095, 0, 1 written; read back matches.
REQ-033 Contention and idle beats: write and read asserted together -> write accepted first, read later returns the new data; a gap in avs_write mid-WRITE -> no extra RAM write.
REQ-034 Reset mid-read: rst pulsed after beat 1 of bc=4 -> no further readdatavalid, waitrequest=1 during reset, 0 the cycle after.
